// File: rtl/unidade_controle.sv
// Round controller for a 16-play memory game.
// Moore FSM: sequences clear / play capture / compare / advance, and
// reports the round outcome (all matched, mismatch or timeout).
module unidade_controle (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       igual,
    input  logic       fimC,
    input  logic       jogada_feita,
    input  logic       timeout,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       db_timeout,
    output logic [3:0] db_estado
);

    localparam logic [3:0] INICIAL     = 4'h0;
    localparam logic [3:0] PREPARACAO  = 4'h1;
    localparam logic [3:0] ESPERA      = 4'h2;
    localparam logic [3:0] REGISTRA    = 4'h4;
    localparam logic [3:0] COMPARA     = 4'h5;
    localparam logic [3:0] PROXIMO     = 4'h6;
    localparam logic [3:0] FIM_ACERTOU = 4'hA;
    localparam logic [3:0] FIM_ERROU   = 4'hE;
    localparam logic [3:0] FIM_TIMEOUT = 4'hD;

    logic [3:0] estado_q;
    logic [3:0] estado_d;

    // State register; reset overrides every other input.
    always_ff @(posedge clock) begin
        if (reset) estado_q <= INICIAL;
        else       estado_q <= estado_d;
    end

    // Next-state logic. Timeout is checked before the play so it wins a tie;
    // the end states look only at iniciar.
    always_comb begin
        estado_d = INICIAL;
        case (estado_q)
            INICIAL:     estado_d = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:  estado_d = ESPERA;
            ESPERA: begin
                if (timeout)           estado_d = FIM_TIMEOUT;
                else if (jogada_feita) estado_d = REGISTRA;
                else                   estado_d = ESPERA;
            end
            REGISTRA:    estado_d = COMPARA;
            COMPARA: begin
                if (!igual)     estado_d = FIM_ERROU;
                else if (fimC)  estado_d = FIM_ACERTOU;
                else            estado_d = PROXIMO;
            end
            PROXIMO:     estado_d = ESPERA;
            FIM_ACERTOU: estado_d = iniciar ? PREPARACAO : FIM_ACERTOU;
            FIM_ERROU:   estado_d = iniciar ? PREPARACAO : FIM_ERROU;
            FIM_TIMEOUT: estado_d = iniciar ? PREPARACAO : FIM_TIMEOUT;
            default:     estado_d = INICIAL;
        endcase
    end

    // Output decode from the current state only (no input-to-output path).
    always_comb begin
        zeraC      = 1'b0;
        contaC     = 1'b0;
        zeraR      = 1'b0;
        registraR  = 1'b0;
        pronto     = 1'b0;
        acertou    = 1'b0;
        errou      = 1'b0;
        db_timeout = 1'b0;
        case (estado_q)
            PREPARACAO: begin
                zeraC = 1'b1;
                zeraR = 1'b1;
            end
            REGISTRA:    registraR = 1'b1;
            PROXIMO:     contaC    = 1'b1;
            FIM_ACERTOU: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_ERROU: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto     = 1'b1;
                db_timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: a phase-level model is compared
// against the DUT after every clock edge, plus literal checks of the
// scenario results and pulse counts.
module tb_unidade_controle;

    logic       clock = 1'b0;
    logic       reset, iniciar, igual, fimC, jogada_feita, timeout;
    logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou, db_timeout;
    logic [3:0] db_estado;

    int checks = 0;
    int errors = 0;
    int cnt_c = 0, cnt_r = 0, cnt_z = 0;

    unidade_controle dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .igual(igual),
        .fimC(fimC), .jogada_feita(jogada_feita), .timeout(timeout),
        .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR), .registraR(registraR),
        .pronto(pronto), .acertou(acertou), .errou(errou),
        .db_timeout(db_timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Round phases as the player sees them.
    typedef enum {P_IDLE, P_CLEAR, P_WAIT, P_CAPTURE, P_CHECK, P_ADVANCE,
                  P_WON, P_LOST, P_TIMED_OUT} phase_t;
    phase_t ph = P_IDLE;

    // Expected {zeraC,contaC,zeraR,registraR,pronto,acertou,errou,db_timeout,db_estado}
    function automatic logic [11:0] expect_out(phase_t p);
        case (p)
            P_CLEAR:     return {8'b1010_0000, 4'h1};
            P_WAIT:      return {8'b0000_0000, 4'h2};
            P_CAPTURE:   return {8'b0001_0000, 4'h4};
            P_CHECK:     return {8'b0000_0000, 4'h5};
            P_ADVANCE:   return {8'b0100_0000, 4'h6};
            P_WON:       return {8'b0000_1100, 4'hA};
            P_LOST:      return {8'b0000_1010, 4'hE};
            P_TIMED_OUT: return {8'b0000_1001, 4'hD};
            default:     return 12'h000;
        endcase
    endfunction

    // Model: advance one phase per clock from the sampled inputs.
    always @(posedge clock) begin
        if (reset) ph <= P_IDLE;
        else case (ph)
            P_IDLE:    if (iniciar) ph <= P_CLEAR;
            P_CLEAR:   ph <= P_WAIT;
            P_WAIT:    if (timeout) ph <= P_TIMED_OUT;
                       else if (jogada_feita) ph <= P_CAPTURE;
            P_CAPTURE: ph <= P_CHECK;
            P_CHECK:   ph <= !igual ? P_LOST : (fimC ? P_WON : P_ADVANCE);
            P_ADVANCE: ph <= P_WAIT;
            default:   if (iniciar) ph <= P_CLEAR;
        endcase
    end

    // Per-cycle compare plus pulse counters, sampled 1 time unit after the edge.
    always @(posedge clock) begin
        logic [11:0] got;
        logic [11:0] exp_v;
        #1;
        got   = {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, db_timeout, db_estado};
        exp_v = expect_out(ph);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL cycle_compare t=%0t got=%h expected=%h", $time, got, exp_v);
        end
        if (contaC)    cnt_c++;
        if (registraR) cnt_r++;
        if (zeraC)     cnt_z++;
    end

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp_v);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic start_round();
        iniciar = 1'b1; cyc(1);
        iniciar = 1'b0; cyc(1);
    endtask

    task automatic play(input logic ig, input logic fc);
        igual = ig; fimC = fc;
        jogada_feita = 1'b1; cyc(1);
        jogada_feita = 1'b0; cyc(3);
    endtask

    logic [7:0] outs;
    always_comb outs = {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, db_timeout};

    initial begin
        reset = 1'b1; iniciar = 1'b0; igual = 1'b0; fimC = 1'b0;
        jogada_feita = 1'b0; timeout = 1'b0;
        cyc(1);
        reset = 1'b0;
        cyc(10);
        chk("idle_state", {12'h0, db_estado}, 16'h0);
        chk("idle_outs", {8'h0, outs}, 16'h0);

        // Full success: 16 matching plays, fimC on the last
        cnt_c = 0; cnt_r = 0;
        start_round();
        chk("ready_espera", {12'h0, db_estado}, 16'h2);
        for (int p = 1; p <= 16; p++) play(1'b1, p == 16);
        fimC = 1'b0;
        chk("win_contaC_count", cnt_c[15:0], 16'd15);
        chk("win_registraR_count", cnt_r[15:0], 16'd16);
        chk("win_state", {12'h0, db_estado}, 16'hA);
        chk("win_flags", {14'h0, pronto, acertou}, 16'h3);

        // Mismatch on the third play
        cnt_c = 0;
        start_round();
        for (int p = 1; p <= 3; p++) play(p != 3, 1'b0);
        chk("lose_state", {12'h0, db_estado}, 16'hE);
        chk("lose_flags", {14'h0, pronto, errou}, 16'h3);
        chk("lose_contaC_count", cnt_c[15:0], 16'd2);

        // Held iniciar in fim_errou restarts exactly once
        cnt_z = 0;
        iniciar = 1'b1; cyc(1);
        chk("restart_prep", {12'h0, db_estado}, 16'h1);
        chk("restart_clear", {14'h0, zeraC, zeraR}, 16'h3);
        cyc(1);
        chk("restart_espera", {12'h0, db_estado}, 16'h2);
        cyc(2);
        chk("restart_held", {12'h0, db_estado}, 16'h2);
        iniciar = 1'b0;
        chk("restart_zeraC_count", cnt_z[15:0], 16'd1);

        // Timeout with no play; end state ignores datapath inputs
        timeout = 1'b1; cyc(1);
        timeout = 1'b0;
        chk("timeout_state", {12'h0, db_estado}, 16'hD);
        chk("timeout_flags", {14'h0, pronto, db_timeout}, 16'h3);
        jogada_feita = 1'b1; igual = 1'b0; timeout = 1'b1; fimC = 1'b1; cyc(2);
        jogada_feita = 1'b0; timeout = 1'b0; fimC = 1'b0;
        chk("timeout_sticky", {12'h0, db_estado}, 16'hD);

        // Timeout and play in the same espera cycle
        start_round();
        cnt_r = 0;
        timeout = 1'b1; jogada_feita = 1'b1; cyc(1);
        timeout = 1'b0; jogada_feita = 1'b0; cyc(2);
        chk("tie_state", {12'h0, db_estado}, 16'hD);
        chk("tie_no_registraR", cnt_r[15:0], 16'd0);

        // Reset while in compara
        start_round();
        igual = 1'b1;
        jogada_feita = 1'b1; cyc(1);
        jogada_feita = 1'b0; cyc(1);
        chk("mid_compara", {12'h0, db_estado}, 16'h5);
        reset = 1'b1; iniciar = 1'b1; cyc(1);
        chk("mid_reset_state", {12'h0, db_estado}, 16'h0);
        chk("mid_reset_outs", {8'h0, outs}, 16'h0);
        cyc(3);
        chk("reset_held", {12'h0, db_estado}, 16'h0);
        reset = 1'b0; iniciar = 1'b0; cyc(3);
        chk("post_reset_idle", {12'h0, db_estado}, 16'h0);
        start_round();
        chk("post_reset_start", {12'h0, db_estado}, 16'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL have these ports, in this order:
- clock  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- iniciar  in  1  start/restart request from the player.
- igual  in  1  datapath compare result: stored play equals the memory word.
- fimC  in  1  datapath address counter terminal count; high at address 15.
- jogada_feita  in  1  single-cycle pulse from the datapath when a play is made.
- timeout  in  1  datapath no-play timeout flag.
- zeraC  out  1  clears the address counter, the edge detector and the timeout counter.
- contaC  out  1  advances the address counter and clears the timeout counter.
- zeraR  out  1  clears the play register.
- registraR  out  1  loads the play register.
- pronto  out  1  round finished.
- acertou  out  1  all 16 plays matched.
- errou  out  1  a play mismatched.
- db_timeout  out  1  round ended by timeout.
- db_estado  out  4  current state code, for debug.

Function
REQ-003 The block SHALL be a Moore FSM with a 4-bit state register.
REQ-004 All outputs SHALL decode from the current state only, with no combinational path from an input to an output.
REQ-005 State codes SHALL be: inicial=0x0, preparacao=0x1, espera=0x2, registra=0x4, compara=0x5, proximo=0x6, fim_acertou=0xA, fim_errou=0xE, fim_timeout=0xD.
REQ-006 Any unused code SHALL go to inicial on the next edge.
REQ-007 db_estado SHALL equal the current state code.
REQ-008 inicial: all control outputs 0; iniciar=1 -> preparacao, else stay.
REQ-009 preparacao: zeraC=1, zeraR=1; -> espera unconditionally.
REQ-010 espera: all control outputs 0; transitions:
- timeout=1 -> fim_timeout;
- else jogada_feita=1 -> registra;
- else stay.
REQ-011 espera: if timeout and jogada_feita are high in the same cycle, timeout SHALL win.
REQ-012 registra: registraR=1; -> compara unconditionally.
REQ-013 compara: all control outputs 0; transitions:
- igual=0 -> fim_errou;
- else fimC=1 -> fim_acertou;
- else -> proximo.
REQ-014 compara: igual SHALL be sampled one cycle after registraR, which covers the register load and the memory read.
REQ-015 proximo: contaC=1; -> espera unconditionally.
REQ-016 fim_acertou: pronto=1, acertou=1.
REQ-017 fim_errou: pronto=1, errou=1.
REQ-018 fim_timeout: pronto=1, db_timeout=1.
REQ-019 In every fim_* state: iniciar=1 -> preparacao, else stay.
REQ-020 In every fim_* state, the datapath inputs SHALL be ignored.
REQ-021 At most one of acertou/errou/db_timeout SHALL be high in any cycle.
REQ-022 pronto SHALL be high exactly when one of acertou/errou/db_timeout is high.
REQ-023 zeraC and contaC SHALL never be high in the same cycle.
REQ-024 registraR SHALL be high for exactly one cycle per accepted jogada_feita pulse.
REQ-025 iniciar SHALL be ignored in every state other than inicial and fim_*.
REQ-026 A held iniciar in a fim_* state SHALL restart the round once; the FSM passes through preparacao, then espera.
REQ-027 Latency, iniciar to round ready:
- iniciar sampled high in inicial at edge k;
- zeraC=1 during cycle k..k+1;
- espera from edge k+1.
REQ-028 Latency, play to result: a jogada_feita pulse sampled at edge j gives registra at j, compara at j+1, and proximo or a fim_* state at j+2.

Reset
REQ-029 reset=1 at a rising edge SHALL force inicial (db_estado=0x0) from any state, including mid-round.
REQ-030 After that reset edge, every output SHALL be 0.
REQ-031 reset SHALL take priority over all other inputs.
REQ-032 While reset is held, the state SHALL remain inicial.
REQ-033 After reset is released, the FSM SHALL leave inicial only on iniciar=1.

Verification
REQ-034 Reset then idle: reset 1 cycle, iniciar=0 for 10 cycles -> db_estado=0x0 and all outputs 0 throughout.
REQ-035 Full success: iniciar pulse; 16 jogada_feita pulses with igual=1 and fimC=1 only on the 16th compare -> exactly 15 contaC pulses and 16 registraR pulses; then db_estado=0xA, pronto=1, acertou=1.
REQ-036 Mismatch at play 3: igual=0 on the 3rd compare -> db_estado=0xE, errou=1, pronto=1; exactly 2 contaC pulses seen.
REQ-037 Timeout: iniciar, then timeout=1 in espera with no play -> db_estado=0xD, db_timeout=1.
REQ-038 Timeout and play together: timeout=1 and jogada_feita=1 in the same espera cycle -> fim_timeout; registraR stays 0.
REQ-039 Restart and mid-round reset, two separate checks:
- iniciar in fim_errou -> preparacao, with zeraC=1 and zeraR=1 for one cycle, then espera;
- reset asserted in compara -> db_estado=0x0 at the next edge, all outputs 0.
